instr_encoder_rv64: RTL

//  Inverse of the core's immediate generator. Packs opcode, register and funct fields plus a

---
 rtl/rv_imm_pkg.sv | 21 ++
 rtl/imm_pack_rv64.sv | 65 ++++++
 rtl/instr_encoder_rv64.sv | 87 ++++++++
 3 files changed

// File: rtl/rv_imm_pkg.sv
// rtl/rv_imm_pkg.sv - immediate format selector and legal ranges shared by encoder and immediate generator
package rv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_src_e;

  localparam longint IS_MIN = -64'sd2048;
  localparam longint IS_MAX = 64'sd2047;
  localparam longint B_MIN  = -64'sd4096;
  localparam longint B_MAX  = 64'sd4094;
  localparam longint J_MIN  = -64'sd1048576;
  localparam longint J_MAX  = 64'sd1048574;
  localparam int     U_LOW  = 12;
  localparam int     U_SIGN = 31;

endpackage

// File: rtl/imm_pack_rv64.sv
// rtl/imm_pack_rv64.sv - combinational instruction packer with per-format immediate range check
module imm_pack_rv64
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      immsrc,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] imm,
  output logic [31:0]     instr,
  output logic            legal
);

  localparam logic signed [XLEN-1:0] IS_LO = XLEN'(IS_MIN);
  localparam logic signed [XLEN-1:0] IS_HI = XLEN'(IS_MAX);
  localparam logic signed [XLEN-1:0] B_LO  = XLEN'(B_MIN);
  localparam logic signed [XLEN-1:0] B_HI  = XLEN'(B_MAX);
  localparam logic signed [XLEN-1:0] J_LO  = XLEN'(J_MIN);
  localparam logic signed [XLEN-1:0] J_HI  = XLEN'(J_MAX);

  logic signed [XLEN-1:0] simm;
  logic                   is_range;
  logic                   u_upper_ok;

  assign simm       = $signed(imm);
  assign is_range   = (simm >= IS_LO) && (simm <= IS_HI);
  // U immediates must be a sign-extended 32-bit value with a clear low page
  assign u_upper_ok = (&imm[XLEN-1:U_SIGN]) || (~|imm[XLEN-1:U_SIGN]);

  always_comb begin
    instr = 32'h0;
    legal = 1'b0;
    case (immsrc)
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        legal = is_range;
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = is_range;
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = (simm >= B_LO) && (simm <= B_HI) && !imm[0];
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        legal = (imm[U_LOW-1:0] == '0) && u_upper_ok;
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = (simm >= J_LO) && (simm <= J_HI) && !imm[0];
      end
      default: begin
        instr = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_rv64.sv
// rtl/instr_encoder_rv64.sv - RV64 instruction encoder streaming packed words with running address
module instr_encoder_rv64
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 10,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_immsrc,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [AW-1:0]   out_addr,
  output logic            err_pulse,
  output logic            err_sticky,
  output logic [CW-1:0]   err_count
);

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        accept;
  logic        xfer;

  imm_pack_rv64 #(.XLEN(XLEN)) u_pack (
    .immsrc (in_immsrc),
    .opcode (in_opcode),
    .rd     (in_rd),
    .funct3 (in_funct3),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .instr  (packed_word),
    .legal  (packed_legal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_addr   <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_addr   <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      err_pulse <= accept && !packed_legal;
      // Address tracks the presented word, so it steps only when a word leaves
      if (xfer) begin
        out_addr <= out_addr + AW'(1);
      end
      if (accept && packed_legal) begin
        out_valid <= 1'b1;
        out_instr <= packed_word;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (accept && !packed_legal) begin
        err_sticky <= 1'b1;
        if (err_count != {CW{1'b1}}) begin
          err_count <= err_count + CW'(1);
        end
      end
    end
  end

endmodule
